// File: rtl/progmem_arbiter.sv
// Two-master arbiter in front of a single program memory port.
// m0 (instruction fetch) and m1 (data) share one slave port; a watchdog aborts stalled transfers.
module progmem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int RR      = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [15:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [15:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] m_dat_o,

  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [15:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  gnt_o
);

  // Handshake: a master raises cyc and holds it (with stable we/sel/adr/dat) until it
  // sees ack or err; while cyc stays high after an ack the grant is kept (bus lock),
  // and dropping cyc releases the grant on the next edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;    // 1: m1 won the most recent grant
  logic [7:0] wdog_q, wdog_d;

  logic granted;
  logic sel_cyc;
  logic timeout;

  always_comb begin
    granted = (state_q != S_IDLE);
    sel_cyc = (state_q == S_GNT1) ? m1_cyc_i : m0_cyc_i;
    // An ack on the last allowed cycle completes the transfer instead of aborting it.
    timeout = granted && (wdog_q == WDOG_LIMIT) && !s_ack_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        wdog_d = 8'd0;
        if (m0_cyc_i && m1_cyc_i) begin
          if ((RR != 0) && !last_q) begin
            state_d = S_GNT1;
            last_d  = 1'b1;
          end else begin
            state_d = S_GNT0;
            last_d  = 1'b0;
          end
        end else if (m0_cyc_i) begin
          state_d = S_GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = S_GNT1;
          last_d  = 1'b1;
        end
      end
      S_GNT0, S_GNT1: begin
        // Always pass through idle between grants so arbitration is re-evaluated.
        if (!sel_cyc || timeout) begin
          state_d = S_IDLE;
        end else if (s_ack_i) begin
          wdog_d = 8'd0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'd0;
    s_adr_o = 16'd0;
    s_dat_o = 32'd0;
    case (state_q)
      S_GNT0: begin
        s_cyc_o = m0_cyc_i && !timeout;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      S_GNT1: begin
        s_cyc_o = m1_cyc_i && !timeout;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: begin
      end
    endcase
  end

  // gnt_o is the one-hot view of the arbiter state.
  always_comb begin
    m0_ack_o = (state_q == S_GNT0) && s_ack_i;
    m1_ack_o = (state_q == S_GNT1) && s_ack_i;
    m0_err_o = (state_q == S_GNT0) && timeout;
    m1_err_o = (state_q == S_GNT1) && timeout;
    gnt_o    = {state_q == S_GNT1, state_q == S_GNT0};
    m_dat_o  = s_dat_i;
  end

endmodule

// File: doc/progmem_arbiter.md
PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of granted cycles without s_ack_i before the arbiter forces an error (range 2..255).
REQ-002 SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with master 0 winning.
REQ-003 SHALL have the following ports (name  direction  width  meaning):
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- m0_cyc_i, m1_cyc_i  in  1  master request/cycle-valid (m0 = instruction fetch, m1 = data).
- m0_we_i, m1_we_i  in  1  write enable.
- m0_sel_i, m1_sel_i  in  4  byte selects.
- m0_adr_i, m1_adr_i  in  16  word address.
- m0_dat_i, m1_dat_i  in  32  write data.
- m0_ack_o, m1_ack_o  out  1  transfer complete.
- m0_err_o, m1_err_o  out  1  transfer aborted by timeout.
- m_dat_o  out  32  read data, shared by both masters.
- s_cyc_o, s_we_o  out  1  memory-side cycle and write enable.
- s_sel_o  out  4  memory-side byte selects.
- s_adr_o  out  16  memory-side address.
- s_dat_o  out  32  memory-side write data.
- s_ack_i  in  1  memory ack.
- s_dat_i  in  32  memory read data.
- gnt_o  out  2  one-hot current grant, 00 when idle.

Function
REQ-004 SHALL implement states S_IDLE, S_GNT0 and S_GNT1, held in a registered state variable.
REQ-005 In S_IDLE with only mX_cyc_i high, the arbiter SHALL enter S_GNTX on the next edge, giving one cycle of grant latency.
REQ-006 In S_IDLE with both requests high and RR=1, the arbiter SHALL grant the master that did not win last; the last-winner bit SHALL reset to 1 so m0 wins the first tie.
REQ-007 In S_IDLE with both requests high and RR=0, the arbiter SHALL always grant m0.
REQ-008 In S_GNTX, s_cyc_o SHALL equal mX_cyc_i, and s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL pass mX's inputs combinationally.
REQ-009 In S_IDLE, all s_* outputs SHALL be 0.
REQ-010 mX_ack_o SHALL equal s_ack_i gated by S_GNTX; the non-granted master's ack and err SHALL be 0.
REQ-011 m_dat_o SHALL equal s_dat_i unconditionally.
REQ-012 The grant SHALL be held while mX_cyc_i stays high, which allows back-to-back transfers (bus lock).
REQ-013 The arbiter SHALL return to S_IDLE on the edge where mX_cyc_i is sampled low; there SHALL be no direct GNT0-to-GNT1 transition, so one idle cycle always separates grants.
REQ-014 An 8-bit watchdog counter SHALL clear on entry to a grant state and on every cycle with s_ack_i high, and SHALL increment on every other granted cycle.
REQ-015 When the watchdog equals TIMEOUT-1 without s_ack_i, mX_err_o SHALL pulse for one cycle, s_cyc_o SHALL be forced 0 in that cycle, and the state SHALL return to S_IDLE.
REQ-016 If s_ack_i and the timeout coincide, the ack SHALL win and no error SHALL be raised.
REQ-017 The last-winner bit SHALL update on every entry to a grant state.
REQ-018 gnt_o SHALL be 01 in S_GNT0, 10 in S_GNT1, and 00 in S_IDLE.

Reset
REQ-019 While rst_ni is low, the block SHALL force state S_IDLE, watchdog 0, last-winner 1, all ack/err outputs 0, gnt_o 00 and all s_* outputs 0, asynchronously and without waiting for a clock edge.
REQ-020 Reset asserted mid-transfer SHALL drop s_cyc_o immediately; no ack SHALL be forwarded after reset asserts.
REQ-021 After reset deasserts, arbitration SHALL resume from S_IDLE on the first clock edge.

Verification
REQ-022 Single read: m0 requests adr 0x0010 with memory acking on the 2nd granted cycle -> gnt_o=01 one cycle after request, m0_ack_o one cycle, m_dat_o = memory word, state back to idle after cyc drops.
REQ-023 Tie with RR=1: both request continuously, each drops cyc after its ack -> grant order m0, m1, m0, m1, with one idle cycle between grants.
REQ-024 Fixed priority: RR=0, both request repeatedly -> m1 is never granted while m0_cyc_i stays asserted.
REQ-025 Byte write: m1 writes 0xAABBCCDD to 0x0100 with sel 0100 -> s_sel_o=0100, s_we_o=1, s_dat_o=0xAABBCCDD, m1_ack_o pulses, m0_ack_o stays 0.
REQ-026 Timeout: TIMEOUT=4 with memory never acking -> m0_err_o pulses on the 4th granted cycle, s_cyc_o is 0 in that cycle, state returns to idle; a separate run with ack coinciding on that cycle gives ack and no err.
REQ-027 Reset mid-grant: rst_ni driven low during S_GNT1 -> s_cyc_o and gnt_o go 0 before the next edge; after release, the next tie is won by m0.
